// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid/ready sequencer for a STAGES-deep chain of external data flops.
// Tracks one valid bit per stage, collapses bubbles, and drives per-stage load
// enables and synchronous clears so a stalled consumer backs the chain up losslessly.
module pipe_ctrl #(
  parameter int STAGES = 4,
  parameter int CW     = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InValid,
  output logic              InReady,
  output logic              OutValid,
  input  logic              OutReady,
  input  logic              Flush,
  output logic [STAGES-1:0] StageEn,
  output logic [STAGES-1:0] StageClr,
  output logic [CW-1:0]     Count,
  output logic              Empty,
  output logic              Full
);

  localparam logic [CW-1:0] FULL_CNT = CW'(STAGES);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_nxt;
  logic [STAGES-1:0] adv;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              kill;
  logic              in_fire;
  logic              out_fire;

  // Advance chain: a stage may take new contents if it is empty or the stage
  // ahead of it is moving; the top stage moves when the consumer is ready.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = OutReady;
    for (int unsigned k = 0; k < STAGES; k++) begin
      adv[STAGES-1-k] = ~v[STAGES-1-k] | carry;
      carry           = adv[STAGES-1-k];
    end
  end

  // Handshake terms, load enables and clears; reset discards exactly like Flush.
  always_comb begin
    kill     = reset | Flush;
    InReady  = adv[0] & ~kill;
    in_fire  = InValid & InReady;
    OutValid = v[STAGES-1] & ~kill;
    out_fire = OutValid & OutReady;
    StageClr = {STAGES{kill}};
    StageEn  = '0;
    StageEn[0] = in_fire;
    for (int unsigned i = 1; i < STAGES; i++) begin
      StageEn[i] = v[i-1] & adv[i] & ~kill;
    end
  end

  // Next valid bits and occupancy; count tracks the popcount of the valid bits.
  always_comb begin
    v_nxt   = v;
    cnt_nxt = cnt;
    if (kill) begin
      v_nxt   = '0;
      cnt_nxt = '0;
    end else begin
      if (adv[0]) begin
        v_nxt[0] = in_fire;
      end
      for (int unsigned i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          v_nxt[i] = v[i-1];
        end
      end
      if (in_fire && !out_fire) begin
        cnt_nxt = cnt + CW'(1);
      end else if (out_fire && !in_fire) begin
        cnt_nxt = cnt - CW'(1);
      end
    end
  end

  // State register: valid bits and occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      v   <= '0;
      cnt <= '0;
    end else begin
      v   <= v_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Status outputs derived from the occupancy counter.
  always_comb begin
    Count = cnt;
    Empty = (cnt == '0);
    Full  = (cnt == FULL_CNT);
  end

  // Structural invariants checked every cycle outside reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(Full && Empty));
      assert ((StageEn & StageClr) == '0);
      assert ($countones(v) == int'(cnt));
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: random and directed stimulus against a slot-level model of the
// pipeline, with behavioural data flops driven by the DUT's enables/clears.
module tb_pipe_ctrl;

  localparam int S  = 4;
  localparam int CW = $clog2(S + 1);

  logic          clk;
  logic          reset;
  logic          InValid;
  logic          InReady;
  logic          OutValid;
  logic          OutReady;
  logic          Flush;
  logic [S-1:0]  StageEn;
  logic [S-1:0]  StageClr;
  logic [CW-1:0] Count;
  logic          Empty;
  logic          Full;

  pipe_ctrl #(.STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Flush    (Flush),
    .StageEn  (StageEn),
    .StageClr (StageClr),
    .Count    (Count),
    .Empty    (Empty),
    .Full     (Full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: slot[i] holds the id of the word in stage i, 0 when empty.
  int slot [S];
  int dreg [S];
  int next_id = 1;
  int accq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs against the model,
  // then advance model, scoreboard and behavioural data flops across the edge.
  task automatic step(input bit iv, input bit ordy, input bit fl, input bit rst);
    int stuck;
    int occ;
    int idx;
    int en_exp;
    int nxt [S];
    bit kill;
    bit acc;
    bit ov;
    logic [S-1:0] en_cap;
    logic [S-1:0] clr_cap;
    @(negedge clk);
    InValid  = iv;
    OutReady = ordy;
    Flush    = fl;
    reset    = rst;
    #1;
    kill = rst | fl;
    // A consumer stall pins the packed run of words ending at the top stage;
    // every other word moves up one place.
    stuck = 0;
    if (slot[S-1] != 0 && !ordy) begin
      idx = S - 1;
      while (idx >= 0) begin
        if (slot[idx] == 0) break;
        stuck++;
        idx--;
      end
    end
    occ = 0;
    foreach (slot[i]) if (slot[i] != 0) occ++;
    acc    = iv && (stuck < S) && !kill;
    ov     = (slot[S-1] != 0) && !kill;
    en_exp = acc ? 1 : 0;
    for (int i = 1; i < S; i++) begin
      if (slot[i-1] != 0 && (i - 1) < (S - stuck) && !kill) en_exp |= (1 << i);
    end
    check("in_ready",  32'(InReady),  32'((stuck < S) && !kill));
    check("out_valid", 32'(OutValid), 32'(ov));
    check("stage_en",  32'(StageEn),  32'(en_exp));
    check("stage_clr", 32'(StageClr), kill ? 32'((1 << S) - 1) : 32'd0);
    check("count",     32'(Count),    32'(occ));
    check("empty",     32'(Empty),    32'(occ == 0));
    check("full",      32'(Full),     32'(occ == S));
    if (ov && ordy) begin
      check("out_data", 32'(dreg[S-1]), 32'(slot[S-1]));
      if (accq.size() > 0) check("out_order", 32'(dreg[S-1]), 32'(accq.pop_front()));
      else check("out_order_empty", 32'(dreg[S-1]), 32'd0);
    end
    en_cap  = StageEn;
    clr_cap = StageClr;
    @(posedge clk);
    #1;
    for (int i = S - 1; i >= 0; i--) begin
      if (clr_cap[i])     dreg[i] = 0;
      else if (en_cap[i]) dreg[i] = (i == 0) ? next_id : dreg[i-1];
    end
    if (kill) begin
      foreach (slot[i]) slot[i] = 0;
      accq.delete();
    end else begin
      foreach (nxt[i]) nxt[i] = 0;
      for (int i = 0; i < S; i++) begin
        if (i < S - stuck) begin
          if (i + 1 < S) nxt[i+1] = slot[i];
        end else begin
          nxt[i] = slot[i];
        end
      end
      if (stuck < S) nxt[0] = acc ? next_id : 0;
      foreach (slot[i]) slot[i] = nxt[i];
      if (acc) accq.push_back(next_id);
    end
    if (acc) next_id++;
    cyc++;
  endtask

  initial begin
    reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b0;
    Flush    = 1'b0;
    foreach (slot[i]) begin
      slot[i] = 0;
      dreg[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(Count),    32'd0);
    check("reset_empty", 32'(Empty),    32'd1);
    check("reset_full",  32'(Full),     32'd0);
    check("reset_ovld",  32'(OutValid), 32'd0);
    reset = 1'b0;
    #1;
    check("reset_irdy",  32'(InReady),  32'd1);

    // Fill with the consumer stalled.
    repeat (6) step(1, 0, 0, 0);
    check("fill_count", 32'(Count),   32'd4);
    check("fill_full",  32'(Full),    32'd1);
    check("fill_irdy",  32'(InReady), 32'd0);

    // Full with simultaneous in/out.
    step(1, 1, 0, 0);
    check("stream_full_count", 32'(Count), 32'd4);

    // Drain one, then flush at Count=3 with a word on offer.
    step(0, 1, 0, 0);
    check("pre_flush_count", 32'(Count), 32'd3);
    step(1, 0, 1, 0);
    check("flush_count", 32'(Count), 32'd0);
    check("flush_empty", 32'(Empty), 32'd1);

    // Continuous stream, then reset mid-stream.
    repeat (10) step(1, 1, 0, 0);
    check("stream_count", 32'(Count), 32'd4);
    step(1, 1, 0, 1);
    check("midreset_count", 32'(Count), 32'd0);
    step(1, 1, 0, 0);
    check("post_reset_accept", 32'(Count), 32'd1);
    step(0, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);

    // Bubble collapse: A, idle, B with the consumer stalled.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    check("bubble_count", 32'(Count),    32'd2);
    check("bubble_ovld",  32'(OutValid), 32'd1);
    step(0, 0, 0, 0);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      bit rdy_bias;
      rdy_bias = ((n / 50) % 2) == 0;
      step($urandom_range(0, 3) != 0,
           rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 47) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
